// File: rtl/instruction_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : instruction_fetch
// Brief    : Fetch stage with a 2-entry buffer that absorbs the 1-cycle
//            memory latency. The IFETCH_LOAD_EN macro adds a program-load
//            write path to the instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [7:0]  out_pc,
    output logic [7:0]  imem_addr,
    output logic        imem_rw_enable,
    output logic [15:0] imem_data_in,
`ifdef IFETCH_LOAD_EN
    input  logic        load_valid,
    input  logic [7:0]  load_addr,
    input  logic [15:0] load_data,
`endif
    input  logic [15:0] imem_data_out
);

    localparam logic [1:0] c_two = 2'd2;

    logic [7:0]  r_pc;
    logic        r_inflight;
    logic [7:0]  r_inflight_pc;
    logic [1:0]  r_count;
    logic        r_head;
    logic [7:0]  r_fifo_pc    [2];
    logic [15:0] r_fifo_instr [2];

    logic        w_load;
    logic        w_pop;
    logic        w_push;
    logic        w_issue;
    logic        w_tail;
    logic [1:0]  w_occupancy;

`ifdef IFETCH_LOAD_EN
    // A load cycle steals the memory port for a write.
    assign w_load         = load_valid;
    assign imem_addr      = load_valid ? load_addr : r_pc;
    assign imem_rw_enable = ~load_valid;
    assign imem_data_in   = load_valid ? load_data : 16'h0000;
`else
    assign w_load         = 1'b0;
    assign imem_addr      = r_pc;
    assign imem_rw_enable = 1'b1;
    assign imem_data_in   = 16'h0000;
`endif

    assign out_valid = (r_count != 2'd0);
    assign out_instr = out_valid ? r_fifo_instr[r_head] : 16'h0000;
    assign out_pc    = out_valid ? r_fifo_pc[r_head]    : 8'h00;

    assign w_pop       = out_valid & out_ready;
    assign w_push      = r_inflight;
    assign w_occupancy = r_count + {1'b0, r_inflight};
    // With two slots, the free slot sits at head when count is 0 or 2.
    assign w_tail      = r_head ^ r_count[0];
    // Buffered + in-flight never exceeds 2, so a push always has room.
    assign w_issue     = fetch_en & ~redirect_valid & ~w_load &
                         ((w_occupancy < c_two) | w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 8'h00;
            r_count       <= 2'd0;
            r_head        <= 1'b0;
        end else if (redirect_valid) begin
            r_pc       <= redirect_pc;
            r_inflight <= 1'b0;
            r_count    <= 2'd0;
            r_head     <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + 8'd1;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Storage needs no reset: outputs are gated by the count.
    always_ff @(posedge clk) begin
        if (rst_n && !redirect_valid && w_push) begin
            r_fifo_pc[w_tail]    <= r_inflight_pc;
            r_fifo_instr[w_tail] <= imem_data_out;
        end
    end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage that drives the 256×16 instruction memory's read port and delivers instructions to decode over a valid/ready handshake. It owns the 8-bit program counter and issues one read per cycle. It absorbs the memory's 1-cycle registered read latency with a 2-entry instruction buffer, so decode stalls never lose data. It accepts PC redirects from downstream and, optionally, a program-load path that drives memory writes.

## Interface
- RESET_PC, 8'h00, PC value loaded on reset.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- fetch_en  in  1  1 = new reads may issue; 0 = hold the PC and issue nothing.
- redirect_valid  in  1  flush the stage and restart at redirect_pc.
- redirect_pc  in  8  new fetch address.
- out_valid  out  1  out_instr/out_pc hold a valid instruction.
- out_ready  in  1  decode accepts the instruction this cycle.
- out_instr  out  16  instruction word.
- out_pc  out  8  address the instruction was fetched from.
- imem_addr  out  8  to memory address.
- imem_rw_enable  out  1  to memory; 1 = read, 0 = write.
- imem_data_in  out  16  to memory write data.
- imem_data_out  in  16  from memory; valid the cycle after a read is issued.
- load_valid / load_addr[8] / load_data[16]  in  program-load write request. Present only with IFETCH_LOAD_EN.

## Operation
- State:
  - pc[7:0]: address of the next read.
  - inflight (1 bit): a read was issued in the previous cycle.
  - inflight_pc[7:0]: address of that read.
  - 2-entry FIFO of {pc, instr} with count 0..2.
- imem_addr = pc and imem_rw_enable = 1, except during a load cycle.
- Issue condition, evaluated in the current cycle:
  - fetch_en = 1, no redirect_valid, and no load cycle; and
  - either count + inflight < 2, or a pop happens this cycle (out_valid && out_ready).
- On issue: inflight <= 1, inflight_pc <= pc, pc <= pc + 1. The PC wraps 8'hFF -> 8'h00.
- Capture: when inflight = 1, push {inflight_pc, imem_data_out} into the FIFO at the end of that cycle. Pop and push in the same cycle is allowed.
- Output: out_valid = (count != 0); out_instr/out_pc = FIFO head. The head is held stable while out_valid && !out_ready.
- Redirect, which has priority over everything else:
  - FIFO cleared; inflight <= 0, so the pending read data is discarded.
  - pc <= redirect_pc.
  - No issue in the redirect cycle.
  - The instruction presented in that cycle is dropped regardless of out_ready.
- fetch_en = 0 does not drain anything: in-flight data is still captured and the FIFO still pops.
- Reset (rst_n = 0 sampled at an edge), including mid-operation:
  - pc <= RESET_PC; inflight <= 0; count <= 0.
  - out_valid = 0, out_instr = 16'h0000, out_pc = 8'h00.
  - imem_rw_enable = 1, imem_data_in = 16'h0000.

## Timing
- Cycle k = interval after edge k.
- Redirect (or reset release) sampled at the end of cycle k:
  - cycle k+1: imem_addr = target, read issued;
  - cycle k+2: memory data valid, pushed at end of cycle;
  - cycle k+3: out_valid = 1 with out_pc = target.
- Redirect/reset-to-first-valid latency: 3 cycles.
- Throughput with out_ready held high: 1 instruction per cycle (steady state count = 1, inflight = 1).
- Stall: at most 2 instructions are buffered plus in flight; issue stops until a pop. No instruction is lost or duplicated.

## Configuration
- IFETCH_LOAD_EN defined:
  - load ports exist.
  - A cycle with load_valid = 1 is a load cycle: imem_rw_enable = 0, imem_addr = load_addr, imem_data_in = load_data, no issue.
  - Capture of a read issued in the previous cycle still completes, because the memory holds its read data during a write.
  - redirect_valid in a load cycle still updates pc and flushes.
- IFETCH_LOAD_EN undefined:
  - no load ports.
  - imem_rw_enable tied to 1; imem_data_in tied to 16'h0000.

## Test plan
- Reset release with RESET_PC = 8'h10, memory[16..18] = 16'hA001..A003, out_ready = 1 -> out_valid rises 3 cycles after reset release, then pc/instr 10/A001, 11/A002, 12/A003 on consecutive cycles.
- out_ready = 0 for 5 cycles mid-stream -> count saturates at 2, imem_addr frozen, head held stable; after release the sequence continues with no gap beyond the buffered entries, no loss, no duplicates.
- Fetch running from 8'hFE -> out_pc sequence FE, FF, 00, 01.
- redirect_valid with redirect_pc = 8'h40 while count = 2 and a read is in flight -> the next valid has out_pc = 40, exactly 3 cycles later; no stale instruction appears.
- rst_n low for 1 cycle during a stalled, full buffer -> out_valid = 0 the next cycle; restart from RESET_PC.
- IFETCH_LOAD_EN: load 8'h05 <- 16'hBEEF, then redirect to 8'h05 -> out_instr = 16'hBEEF; during the load cycle imem_rw_enable = 0.
